fpnew_norm_round_prep: RTL and testbench
========================================

# fpnew_norm_round_prep

Multi-cycle normalizer that feeds the FPU rounding stage. It accepts a wide, unnormalized significand with a biased exponent, and shifts it iteratively until it is normalized or has become a denormal. It then packs the `{exponent, mantissa}` absolute value together with the round/sticky bits and the stochastic-rounding bits that the rounder consumes. It sits between the datapath that computes the wide result (FMA/DIVSQRT) and the rounding logic, and uses valid/ready handshakes on both sides.

## Interface
**Parameters**
- `ExpBits`, 8: exponent field width.
- `ManBits`, 23: mantissa field width, excluding the hidden bit.
- `InWidth`, 48: input significand width. Must satisfy `InWidth >= ManBits+2+RsrPrecision`.
- `ShiftStep`, 8: maximum shift distance per cycle, ≥1.
- `RsrPrecision`, 12: width of the stochastic-rounding bits.

**Ports**
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `in_valid_i` in 1: input valid.
- `in_ready_o` out 1: input ready.
- `mant_i` in `InWidth`: unsigned significand. Binary point sits below bit `InWidth-1`.
- `exp_i` in `ExpBits+2`: signed biased exponent.
- `sign_i` in 1: sign, passed through.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: result ready.
- `abs_value_o` out `ExpBits+ManBits`: packed absolute value.
- `round_sticky_o` out 2: `{round, sticky}`.
- `stoch_bits_o` out `RsrPrecision`: bits directly below the ULP.
- `sign_o` out 1: registered sign.
- `of_o` out 1: overflow, exponent saturated.

## Operation
**States**
- `IDLE`: `in_ready_o=1`.
- `LSHIFT`: iterative left shift.
- `RSHIFT`: iterative right shift.
- `OUT`: `out_valid_o=1`.

**Capture.** Accept happens in `IDLE` when `in_valid_i`. The block registers `mant_i`, `exp_i` and `sign_i`, and clears the sticky accumulator. It also computes the shift count `n`:
- `mant_i == 0`: `n=0`, go to `OUT`, result zero.
- `exp_i < 1`: right shift, `n = min(1-exp_i, InWidth+1)`. Go to `RSHIFT`, or `OUT` if `n=0`.
- Otherwise: left shift, `n = min(lzc(mant_i), exp_i-1)`. Go to `LSHIFT`, or `OUT` if `n=0`.

**Shifting.** Each `LSHIFT`/`RSHIFT` cycle:
- Shift by `s = min(remaining, ShiftStep)` and subtract `s` from the count.
- The exponent changes by ∓s.
- In `RSHIFT`, every bit shifted out is OR-ed into the sticky accumulator.
- When the count reaches 0, go to `OUT`.

**Packing in `OUT`** (combinational from registers):
- Exponent field: `0` if `exp==1` and the significand MSB is 0 (denormal); otherwise `exp[ExpBits-1:0]`.
- Mantissa field: bits `[InWidth-2 -: ManBits]`.
- Round bit: the next lower bit.
- Sticky: OR of all remaining lower bits | sticky accumulator.
- `stoch_bits_o`: the `RsrPrecision` bits starting at the round bit.
- Zero input: all outputs zero.

**Overflow.** If `exp >= 2^ExpBits-1` after normalization:
- `of_o=1`.
- `abs_value_o = {all-ones exponent, 0}`.
- `round_sticky_o = 00`, `stoch_bits_o = 0`.

**Leaving `OUT`.** On `out_valid_o & out_ready_i`, go to `IDLE`.
- There is no input acceptance in `OUT`, so there is no back-to-back overlap.

## Timing
- **Latency.** `out_valid_o` asserts `1+ceil(n/ShiftStep)` cycles after the accept edge. A zero or already-normal input therefore takes 1 cycle.
- **Throughput.** One operation in flight. `in_ready_o` is low from the cycle after accept until the cycle after the output handshake.
- **Output stability.** While `out_valid_o=1` and `out_ready_i=0`, all outputs hold stable.
- **Reset values.** On `rst_i` (checked only at a clock edge): state `IDLE`, `in_ready_o=1`, `out_valid_o=0`. All data outputs, `of_o` and the sticky accumulator are 0.
- **Reset mid-operation.** Reset during any state aborts the operation with no output.
- **Ignored inputs.** `in_valid_i` is ignored outside `IDLE`. `out_ready_i` is ignored outside `OUT`.
- **Large denormal shifts.** A right-shift count of `InWidth+1` or more leaves the significand 0 with sticky = OR of the input.

## Configuration
- **Macro:** `FPNEW_NORM_RSR_EN`.
- **Defined:** the `stoch_bits_o` extraction logic and its register path are present.
- **Undefined:** `stoch_bits_o` is tied to `'0` and the extraction logic is removed. All other behaviour is identical.

## Test plan
All scenarios use default parameters.
- **Normal, no shift.** `mant=48'h8000_0000_0000`, `exp=127`. Expect `abs=0x3F800000`, `rs=00`, `of=0`; `out_valid` 1 cycle after accept.
- **Maximum left shift.** `mant=48'h0000_0000_0001`, `exp=200`. Expect a 47-bit left shift, `abs=0x4C800000` (exp 153), latency 7 cycles.
- **Denormal.** `mant=48'hC000_0000_0000`, `exp=-1`. Expect a right shift of 2, `abs=0x00300000`, `rs=00`, latency 2. Repeat with `mant=48'h8000_0000_0001`, `exp=-49` and expect `abs=0`, `rs=01`.
- **Sticky.** `mant=48'h8000_0000_0001`, `exp=127`. Expect `abs=0x3F800000`, `rs=01`; `stoch_bits_o=0` when `FPNEW_NORM_RSR_EN` is defined.
- **Overflow.** `mant=48'h8000_0000_0000`, `exp=255`. Expect `of_o=1`, `abs=0x7F800000`, `rs=00`.
- **Backpressure and reset.**
  - Hold `out_ready_i=0` for 3 cycles: outputs stay stable and `in_ready_o=0`.
  - Assert `rst_i` mid-`LSHIFT`: next cycle `IDLE` with `out_valid_o=0` and no output produced.

Source files
------------

// File: rtl/fpnew_norm_round_prep.sv
// Iterative normalizer feeding the FPU rounder: shifts a wide significand until normal/denormal, then packs {exp, mant}, round/sticky.
// Optional macro FPNEW_NORM_RSR_EN enables the stochastic-rounding bit output; otherwise stoch_bits_o is tied to zero.
module fpnew_norm_round_prep #(
  parameter int unsigned ExpBits      = 8,
  parameter int unsigned ManBits      = 23,
  parameter int unsigned InWidth      = 48,
  parameter int unsigned ShiftStep    = 8,
  parameter int unsigned RsrPrecision = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [InWidth-1:0]         mant_i,
  input  logic [ExpBits+1:0]         exp_i,
  input  logic                       sign_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ExpBits+ManBits-1:0] abs_value_o,
  output logic [1:0]                 round_sticky_o,
  output logic [RsrPrecision-1:0]    stoch_bits_o,
  output logic                       sign_o,
  output logic                       of_o
);

  localparam int unsigned EW       = ExpBits + 2;
  localparam int unsigned CntW     = $clog2(InWidth + 2);
  localparam int unsigned StepCap  = (ShiftStep > InWidth + 1) ? InWidth + 1 : ShiftStep;
  localparam int unsigned RoundIdx = InWidth - ManBits - 2;
  localparam logic signed [EW-1:0] ExpMax = EW'((1 << ExpBits) - 1);
  localparam logic signed [EW-1:0] ExpOne = EW'(1);

  typedef enum logic [1:0] {IDLE, LSHIFT, RSHIFT, OUT} state_e;

  state_e                 state;
  logic [InWidth-1:0]     mant_q;
  logic signed [EW-1:0]   exp_q;
  logic                   sign_q;
  logic                   sticky_q;
  logic                   zero_q;
  logic [CntW-1:0]        cnt_q;

  int unsigned            lzc;
  logic                   found;
  int                     exp_in;
  int                     n;
  logic [CntW-1:0]        n_cap;
  state_e                 cap_next;
  logic [CntW-1:0]        step;
  logic [InWidth-1:0]     lost_mask;

  always_comb begin
    lzc   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < InWidth; i++) begin
      if (!found) begin
        if (mant_i[InWidth-1-i]) found = 1'b1;
        else                     lzc++;
      end
    end
  end

  // Right shift when the exponent is below the normal range, else left shift limited by exponent headroom.
  always_comb begin
    exp_in   = int'($signed(exp_i));
    n        = 0;
    cap_next = OUT;
    if (mant_i == '0) begin
      n        = 0;
      cap_next = OUT;
    end else if (exp_in < 1) begin
      n = 1 - exp_in;
      if (n > int'(InWidth) + 1) n = int'(InWidth) + 1;
      cap_next = RSHIFT;
    end else begin
      n        = (int'(lzc) < exp_in - 1) ? int'(lzc) : exp_in - 1;
      cap_next = (n == 0) ? OUT : LSHIFT;
    end
    n_cap = CntW'(n);
  end

  assign step      = (cnt_q > CntW'(StepCap)) ? CntW'(StepCap) : cnt_q;
  assign lost_mask = ~({InWidth{1'b1}} << step);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          mant_q   <= mant_i;
          exp_q    <= exp_i;
          sign_q   <= sign_i;
          sticky_q <= 1'b0;
          zero_q   <= (mant_i == '0);
          cnt_q    <= n_cap;
          state    <= cap_next;
        end
        LSHIFT: begin
          mant_q <= mant_q << step;
          exp_q  <= exp_q - EW'(step);
          cnt_q  <= cnt_q - step;
          if (cnt_q == step) state <= OUT;
        end
        RSHIFT: begin
          mant_q   <= mant_q >> step;
          sticky_q <= sticky_q | (|(mant_q & lost_mask));
          exp_q    <= exp_q + EW'(step);
          cnt_q    <= cnt_q - step;
          if (cnt_q == step) state <= OUT;
        end
        OUT: if (out_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic               data_vld;
  logic [ExpBits-1:0] exp_field;

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == OUT);
  assign data_vld    = (state == OUT) && !zero_q;
  assign of_o        = data_vld && (exp_q >= ExpMax);
  assign sign_o      = data_vld && sign_q;
  // exp <= 1 also covers saturated right shifts that never reach exponent 1; the significand is zero there.
  assign exp_field   = ((exp_q <= ExpOne) && !mant_q[InWidth-1]) ? '0 : exp_q[ExpBits-1:0];

  always_comb begin
    abs_value_o    = '0;
    round_sticky_o = '0;
    if (of_o) begin
      abs_value_o = {{ExpBits{1'b1}}, {ManBits{1'b0}}};
    end else if (data_vld) begin
      abs_value_o    = {exp_field, mant_q[InWidth-2 -: ManBits]};
      round_sticky_o = {mant_q[RoundIdx], (|mant_q[RoundIdx-1:0]) | sticky_q};
    end
  end

`ifdef FPNEW_NORM_RSR_EN
  assign stoch_bits_o = (data_vld && !of_o) ? mant_q[RoundIdx -: RsrPrecision] : '0;
`else
  assign stoch_bits_o = '0;
`endif

endmodule

// File: tb/tb_fpnew_norm_round_prep.sv
// Directed bench for fpnew_norm_round_prep with hand-computed results (default parameters).
module tb_fpnew_norm_round_prep;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] mant;
  logic [9:0]  exp;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] abs_val;
  logic [1:0]  rs;
  logic [11:0] stoch;
  logic        sign_out;
  logic        of;

  int checks = 0;
  int errors = 0;

  fpnew_norm_round_prep #(
    .ExpBits(8), .ManBits(23), .InWidth(48), .ShiftStep(8), .RsrPrecision(12)
  ) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mant_i(mant), .exp_i(exp), .sign_i(sign_in), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .abs_value_o(abs_val), .round_sticky_o(rs),
    .stoch_bits_o(stoch), .sign_o(sign_out), .of_o(of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic run_op(input string tag, input logic [47:0] m, input logic [9:0] e,
                        input logic s, input int lat, input logic [30:0] a,
                        input logic [1:0] r, input logic o, input logic so,
                        input logic [11:0] st, input int hold);
    int cyc;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    mant = m; exp = e; sign_in = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; mant = '0; exp = '0; sign_in = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_in_ready_busy"}, in_ready, 0);
    check({tag, "_abs"}, abs_val, a);
    check({tag, "_rs"}, rs, r);
    check({tag, "_of"}, of, o);
    check({tag, "_sign"}, sign_out, so);
`ifdef FPNEW_NORM_RSR_EN
    check({tag, "_stoch"}, stoch, st);
`else
    check({tag, "_stoch"}, stoch, 12'h0);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      mant = {$urandom, $urandom_range(65535, 1)};
      exp  = 10'd5;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_in_ready"}, in_ready, 0);
      check({tag, "_hold_abs"}, abs_val, a);
      check({tag, "_hold_rs"}, rs, r);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_done_valid"}, out_valid, 0);
    check({tag, "_done_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mant = '0; exp = '0; sign_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_abs", abs_val, 0);
    check("reset_rs", rs, 0);
    check("reset_of", of, 0);
    check("reset_stoch", stoch, 0);
    check("reset_sign", sign_out, 0);

    //      tag          mant                exp       s     lat  abs            rs     of    so    stoch    hold
    run_op("normal",    48'h8000_0000_0000, 10'd127,  1'b0, 1,   31'h3F800000, 2'b00, 1'b0, 1'b0, 12'h000, 0);
    run_op("backpress", 48'h8000_0000_0000, 10'd127,  1'b1, 1,   31'h3F800000, 2'b00, 1'b0, 1'b1, 12'h000, 3);
    run_op("max_left",  48'h0000_0000_0001, 10'd200,  1'b0, 7,   31'h4C800000, 2'b00, 1'b0, 1'b0, 12'h000, 0);
    run_op("denorm2",   48'hC000_0000_0000, 10'h3FF,  1'b0, 2,   31'h00300000, 2'b00, 1'b0, 1'b0, 12'h000, 0);
    run_op("denorm49",  48'h8000_0000_0001, 10'h3CF,  1'b1, 8,   31'h00000000, 2'b01, 1'b0, 1'b1, 12'h000, 0);
    run_op("sticky",    48'h8000_0000_0001, 10'd127,  1'b0, 1,   31'h3F800000, 2'b01, 1'b0, 1'b0, 12'h000, 0);
    run_op("rsr_bits",  48'h8000_00AB_C000, 10'd127,  1'b0, 1,   31'h3F800000, 2'b11, 1'b0, 1'b0, 12'hABC, 0);
    run_op("overflow",  48'h8000_0000_0000, 10'd255,  1'b0, 1,   31'h7F800000, 2'b00, 1'b1, 1'b0, 12'h000, 0);
    run_op("of_shift",  48'h4000_0000_0000, 10'd300,  1'b1, 2,   31'h7F800000, 2'b00, 1'b1, 1'b1, 12'h000, 0);
    run_op("exp_limit", 48'h0000_0100_0000, 10'd10,   1'b0, 3,   31'h00000200, 2'b00, 1'b0, 1'b0, 12'h000, 0);
    run_op("zero",      48'h0000_0000_0000, 10'd300,  1'b1, 1,   31'h00000000, 2'b00, 1'b0, 1'b0, 12'h000, 0);

    // Reset in the middle of a 47-bit left shift.
    mant = 48'h0000_0000_0001; exp = 10'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_abs", abs_val, 0);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("midrst_no_output", seen, 0);

    run_op("after_rst", 48'h8000_0000_0001, 10'd127, 1'b0, 1, 31'h3F800000, 2'b01, 1'b0, 1'b0, 12'h000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
